// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its two requesters (fetch, data) and the shared memory port.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic [1:0]        i_status;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic [1:0]        d_status;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;
  logic              owner;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_status, d_rdata, d_status, m_req, m_we, m_addr, m_wdata, owner
  );

  // Requesters plus memory model view
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_status, d_rdata, d_status, m_req, m_we, m_addr, m_wdata, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters (IDLE/WAIT/DONE, ack timeout).
// Define MEM_ARB_FAIRNESS_EN to add the fetch anti-starvation counter.
module mem_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int               TMO_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_PEND = 2'b01;
  localparam logic [1:0] STAT_DONE = 2'b10;
  localparam logic [1:0] STAT_ERR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]        i_status_q, i_status_d;
  logic [1:0]        d_status_q, d_status_d;
  logic              owner_q, owner_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic              fetch_turn;
  logic              grant_d;
  logic              grant_i;

  function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] v);
    return (v == TMO_MAX) ? v : v + TMO_W'(1);
  endfunction

  // Data wins a tie unless the fairness counter has handed the turn to fetch.
  assign grant_d = bus.d_req && !(bus.i_req && fetch_turn);
  assign grant_i = bus.i_req && !grant_d;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int               STV_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  logic [STV_W-1:0] starve_q, starve_d;

  function automatic logic [STV_W-1:0] starve_inc(input logic [STV_W-1:0] v);
    return (v == STV_MAX) ? v : v + STV_W'(1);
  endfunction

  assign fetch_turn = (starve_q == STV_MAX);

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (grant_i) begin
        starve_d = '0;
      end else if (grant_d && bus.i_req) begin
        starve_d = starve_inc(starve_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_cfg;
  assign fetch_turn        = 1'b0;
  assign unused_starve_cfg = (STARVE_LIMIT != 0);
`endif

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    owner_d    = owner_q;
    tmo_cnt_d  = tmo_cnt_q;
    i_status_d = bus.i_req ? STAT_PEND : STAT_IDLE;
    d_status_d = bus.d_req ? STAT_PEND : STAT_IDLE;

    unique case (state_q)
      S_IDLE: begin
        if (grant_d || grant_i) begin
          state_d   = S_WAIT;
          m_req_d   = 1'b1;
          tmo_cnt_d = '0;
          owner_d   = grant_d;
          if (grant_d) begin
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = bus.i_addr;
            m_wdata_d = '0;
          end
        end
      end

      S_WAIT: begin
        // The owner stays pending even if it dropped its request mid-transaction.
        if (owner_q) begin
          d_status_d = STAT_PEND;
        end else begin
          i_status_d = STAT_PEND;
        end

        if (bus.m_ack) begin
          state_d = S_DONE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (owner_q) begin
            d_rdata_d  = bus.m_rdata;
            d_status_d = STAT_DONE;
          end else begin
            i_rdata_d  = bus.m_rdata;
            i_status_d = STAT_DONE;
          end
        end else if (tmo_cnt_q == TMO_MAX) begin
          state_d = S_DONE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (owner_q) begin
            d_status_d = STAT_ERR;
          end else begin
            i_status_d = STAT_ERR;
          end
        end else begin
          tmo_cnt_d = tmo_inc(tmo_cnt_q);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        m_req_d = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_status_q <= STAT_IDLE;
      d_status_q <= STAT_IDLE;
      owner_q    <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_status_q <= i_status_d;
      d_status_q <= d_status_d;
      owner_q    <= owner_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_status = i_status_q;
  assign bus.d_status = d_status_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus reset, contention and timeout sequences.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .STARVE_LIMIT(4),
    .TIMEOUT     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        e_m_req;
    logic        e_m_we;
    logic [31:0] e_m_addr;
    logic [31:0] e_m_wdata;
    logic [1:0]  e_i_st;
    logic [1:0]  e_d_st;
    logic [31:0] e_i_rd;
    logic [31:0] e_d_rd;
    logic        e_owner;
  } vec_t;

  vec_t tbl[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_dr;
    logic        exp_own;
    int          lat;

    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.i_req    = 1'b0;
    bus.i_addr   = 32'h0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h0;
    bus.d_wdata  = 32'h0;
    bus.m_ack    = 1'b0;
    bus.m_rdata  = 32'h0;

    //            rst   ireq  iaddr         dreq  dwe   daddr         dwdata        mack  mrdata        | mreq mwe   maddr         mwdata        ist    dst    i_rdata       d_rdata       owner
    tbl[0]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 2'b00, 2'b00, 32'h00000000, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h00400004, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 2'b00, 2'b00, 32'h00000000, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'h00400004, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00400004, 32'h00000000, 2'b01, 2'b00, 32'h00000000, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h00400004, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00400004, 32'h00000000, 2'b01, 2'b00, 32'h00000000, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h00400004, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h8C080000, 1'b0, 1'b0, 32'h00400004, 32'h00000000, 2'b10, 2'b00, 32'h8C080000, 32'h00000000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h00400004, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00400004, 32'h00000000, 2'b00, 2'b00, 32'h8C080000, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'h00400004, 1'b1, 1'b1, 32'h10010000, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h10010000, 32'hDEADBEEF, 2'b00, 2'b01, 32'h8C080000, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h00400004, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h10010000, 32'hDEADBEEF, 2'b00, 2'b01, 32'h8C080000, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h00400004, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000000, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 32'h10010000, 32'hDEADBEEF, 2'b00, 2'b10, 32'h8C080000, 32'h0BADF00D, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h00400004, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h10010000, 32'hDEADBEEF, 2'b00, 2'b00, 32'h8C080000, 32'h0BADF00D, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 32'h00400004, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000000, 1'b1, 32'h11111111, 1'b0, 1'b0, 32'h10010000, 32'hDEADBEEF, 2'b00, 2'b00, 32'h8C080000, 32'h0BADF00D, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h00400004, 1'b1, 1'b0, 32'h10010004, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h10010004, 32'h00000000, 2'b00, 2'b01, 32'h8C080000, 32'h0BADF00D, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 32'h00400008, 1'b1, 1'b0, 32'h10010004, 32'h00000000, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h10010004, 32'h00000000, 2'b01, 2'b10, 32'h8C080000, 32'hCAFEF00D, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 32'h00400008, 1'b0, 1'b0, 32'h10010004, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h10010004, 32'h00000000, 2'b01, 2'b00, 32'h8C080000, 32'hCAFEF00D, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 32'h00400008, 1'b0, 1'b0, 32'h10010004, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00400008, 32'h00000000, 2'b01, 2'b00, 32'h8C080000, 32'hCAFEF00D, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 32'h00400008, 1'b0, 1'b0, 32'h10010004, 32'h00000000, 1'b1, 32'h22222222, 1'b0, 1'b0, 32'h00400008, 32'h00000000, 2'b10, 2'b00, 32'h22222222, 32'hCAFEF00D, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 32'h00400008, 1'b0, 1'b0, 32'h10010004, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00400008, 32'h00000000, 2'b00, 2'b00, 32'h22222222, 32'hCAFEF00D, 1'b0};

    for (int i = 0; i < 17; i++) begin
      rst         = tbl[i].rst;
      bus.i_req   = tbl[i].i_req;
      bus.i_addr  = tbl[i].i_addr;
      bus.d_req   = tbl[i].d_req;
      bus.d_we    = tbl[i].d_we;
      bus.d_addr  = tbl[i].d_addr;
      bus.d_wdata = tbl[i].d_wdata;
      bus.m_ack   = tbl[i].m_ack;
      bus.m_rdata = tbl[i].m_rdata;
      tick();
      chk($sformatf("r%0d m_req", i),    32'(bus.m_req),    32'(tbl[i].e_m_req));
      chk($sformatf("r%0d m_we", i),     32'(bus.m_we),     32'(tbl[i].e_m_we));
      chk($sformatf("r%0d m_addr", i),   bus.m_addr,        tbl[i].e_m_addr);
      chk($sformatf("r%0d m_wdata", i),  bus.m_wdata,       tbl[i].e_m_wdata);
      chk($sformatf("r%0d i_status", i), 32'(bus.i_status), 32'(tbl[i].e_i_st));
      chk($sformatf("r%0d d_status", i), 32'(bus.d_status), 32'(tbl[i].e_d_st));
      chk($sformatf("r%0d i_rdata", i),  bus.i_rdata,       tbl[i].e_i_rd);
      chk($sformatf("r%0d d_rdata", i),  bus.d_rdata,       tbl[i].e_d_rd);
      chk($sformatf("r%0d owner", i),    32'(bus.owner),    32'(tbl[i].e_owner));
    end

    // Reset while a data transaction is in WAIT, then a stray ack.
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h00000020;
    bus.m_ack  = 1'b0;
    tick();
    chk("rstw grant m_req", 32'(bus.m_req), 32'd1);
    tick();
    chk("rstw wait m_req", 32'(bus.m_req), 32'd1);
    rst = 1'b0;
    tick();
    chk("rstw m_req", 32'(bus.m_req), 32'd0);
    chk("rstw d_status", 32'(bus.d_status), 32'd0);
    chk("rstw i_status", 32'(bus.i_status), 32'd0);
    chk("rstw d_rdata", bus.d_rdata, 32'h0);
    chk("rstw i_rdata", bus.i_rdata, 32'h0);
    chk("rstw m_addr", bus.m_addr, 32'h0);
    rst         = 1'b1;
    bus.d_req   = 1'b0;
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h5A5A5A5A;
    tick();
    chk("late ack d_status", 32'(bus.d_status), 32'd0);
    chk("late ack d_rdata", bus.d_rdata, 32'h0);
    chk("late ack m_req", 32'(bus.m_req), 32'd0);
    bus.m_ack = 1'b0;

    // Both requesters held high, ack one cycle after m_req rises.
    exp_dr     = 32'h0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h00000200;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h00000100;
    for (int n = 0; n < 10; n++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      exp_own = (n % 5 == 4) ? 1'b0 : 1'b1;
`else
      exp_own = 1'b1;
`endif
      tick();
      chk($sformatf("both t%0d m_req", n), 32'(bus.m_req), 32'd1);
      chk($sformatf("both t%0d owner", n), 32'(bus.owner), 32'(exp_own));
      chk($sformatf("both t%0d i_status grant", n), 32'(bus.i_status), 32'd1);
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h50000000 + 32'(n);
      tick();
      if (exp_own) exp_dr = 32'h50000000 + 32'(n);
      chk($sformatf("both t%0d d_status done", n), 32'(bus.d_status), exp_own ? 32'd2 : 32'd1);
      chk($sformatf("both t%0d i_status done", n), 32'(bus.i_status), exp_own ? 32'd1 : 32'd2);
      chk($sformatf("both t%0d d_rdata", n), bus.d_rdata, exp_dr);
      bus.m_ack = 1'b0;
      tick();
      chk($sformatf("both t%0d i_status idle", n), 32'(bus.i_status), 32'd1);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    chk("both end i_status", 32'(bus.i_status), 32'd0);
    chk("both end d_status", 32'(bus.d_status), 32'd0);

    // Timeout: ack never arrives.
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h00000040;
    tick();
    chk("tmo m_req rise", 32'(bus.m_req), 32'd1);
    lat = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.d_status == 2'b11) begin
        lat = t;
        break;
      end
    end
    chk("tmo latency", 32'(lat), 32'd9);
    chk("tmo m_req", 32'(bus.m_req), 32'd0);
    chk("tmo d_rdata", bus.d_rdata, exp_dr);
    tick();
    chk("tmo after d_status", 32'(bus.d_status), 32'd1);
    tick();
    chk("tmo regrant m_req", 32'(bus.m_req), 32'd1);
    chk("tmo regrant d_status", 32'(bus.d_status), 32'd1);
    bus.d_req   = 1'b0;
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h77777777;
    tick();
    chk("tmo final done", 32'(bus.d_status), 32'd2);
    bus.m_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
